sdram_mport_arb: RTL and testbench

SDRAM_MPORT_ARB -- requirements
Module: sdram_mport_arb

---
 rtl/sdram_mport_arb_if.sv | 63 ++++++
 rtl/sdram_mport_arb.sv | 235 +++++++++++++++++++++++
 tb/tb_sdram_mport_arb.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_mport_arb_if.sv
// sdram_mport_arb_if
//   Bundles every signal around the multi-port SDRAM arbiter except the
//   clock and reset.
//
//   Port-side signals (packed, port i at [i*W +: W]):
//     p_wr_req/p_rd_req, p_wr_addr/p_rd_addr, p_wr_len/p_rd_len, p_wr_data
//     p_wr_ack/p_rd_ack, p_rd_data, p_done, p_err
//   Controller-side signals:
//     init_end, sdram_wr_req/sdram_rd_req, sdram_*_addr, sdram_*_len,
//     sdram_wr_data, sdram_wr_ack/sdram_rd_ack, sdram_rd_data
//   Status:
//     grant_id (index of the granted port, valid while busy)
//
//   Modports:
//     slave  - the arbiter's view
//     master - the view of everything around the arbiter (ports + controller)
interface sdram_mport_arb_if #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 10
);
  logic                        init_end;
  logic [N_PORTS-1:0]          p_wr_req;
  logic [N_PORTS-1:0]          p_rd_req;
  logic [N_PORTS*ADDR_W-1:0]   p_wr_addr;
  logic [N_PORTS*ADDR_W-1:0]   p_rd_addr;
  logic [N_PORTS*LEN_W-1:0]    p_wr_len;
  logic [N_PORTS*LEN_W-1:0]    p_rd_len;
  logic [N_PORTS*DATA_W-1:0]   p_wr_data;
  logic [N_PORTS-1:0]          p_wr_ack;
  logic [N_PORTS-1:0]          p_rd_ack;
  logic [DATA_W-1:0]           p_rd_data;
  logic [N_PORTS-1:0]          p_done;
  logic [N_PORTS-1:0]          p_err;
  logic                        sdram_wr_req;
  logic                        sdram_rd_req;
  logic [ADDR_W-1:0]           sdram_wr_addr;
  logic [ADDR_W-1:0]           sdram_rd_addr;
  logic [LEN_W-1:0]            sdram_wr_len;
  logic [LEN_W-1:0]            sdram_rd_len;
  logic [DATA_W-1:0]           sdram_wr_data;
  logic                        sdram_wr_ack;
  logic                        sdram_rd_ack;
  logic [DATA_W-1:0]           sdram_rd_data;
  logic [2:0]                  grant_id;

  modport slave (
    input  init_end, p_wr_req, p_rd_req, p_wr_addr, p_rd_addr, p_wr_len,
           p_rd_len, p_wr_data, sdram_wr_ack, sdram_rd_ack, sdram_rd_data,
    output p_wr_ack, p_rd_ack, p_rd_data, p_done, p_err, sdram_wr_req,
           sdram_rd_req, sdram_wr_addr, sdram_rd_addr, sdram_wr_len,
           sdram_rd_len, sdram_wr_data, grant_id
  );

  modport master (
    output init_end, p_wr_req, p_rd_req, p_wr_addr, p_rd_addr, p_wr_len,
           p_rd_len, p_wr_data, sdram_wr_ack, sdram_rd_ack, sdram_rd_data,
    input  p_wr_ack, p_rd_ack, p_rd_data, p_done, p_err, sdram_wr_req,
           sdram_rd_req, sdram_wr_addr, sdram_rd_addr, sdram_wr_len,
           sdram_rd_len, sdram_wr_data, grant_id
  );
endinterface

// File: rtl/sdram_mport_arb.sv
// sdram_mport_arb
//   Arbitrates N_PORTS burst masters onto a single SDRAM controller
//   read/write request interface. One burst is in flight at a time; the
//   granted port's address/length are latched, its data strobes are
//   forwarded, and a one-cycle p_done (burst complete) or p_err (controller
//   never acknowledged within TIMEOUT cycles) pulse closes the transaction.
//
//   Ports:
//     sys_clk - rising-edge clock
//     sys_rst - asynchronous active-high reset
//     bus     - sdram_mport_arb_if.slave (port side + controller side)
module sdram_mport_arb #(
  parameter int N_PORTS = 4,
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 10,
  parameter int RR_EN   = 1,
  parameter int WR_PRIO = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  sdram_mport_arb_if.slave bus
);
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_PORT = IDX_W'(N_PORTS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_BURST,
    RD_WAIT,
    RD_BURST
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_req_q, wr_req_d;
  logic               rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [LEN_W-1:0]   wr_len_q, wr_len_d;
  logic [LEN_W-1:0]   rd_len_q, rd_len_d;
  logic [N_PORTS-1:0] done_q, done_d;
  logic [N_PORTS-1:0] err_q, err_d;

  // Per-port views of the packed buses.
  logic [ADDR_W-1:0] wr_addr_arr [N_PORTS];
  logic [ADDR_W-1:0] rd_addr_arr [N_PORTS];
  logic [LEN_W-1:0]  wr_len_arr  [N_PORTS];
  logic [LEN_W-1:0]  rd_len_arr  [N_PORTS];
  logic [DATA_W-1:0] wr_data_arr [N_PORTS];

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_unpack
      assign wr_addr_arr[gi] = bus.p_wr_addr[gi*ADDR_W +: ADDR_W];
      assign rd_addr_arr[gi] = bus.p_rd_addr[gi*ADDR_W +: ADDR_W];
      assign wr_len_arr[gi]  = bus.p_wr_len[gi*LEN_W +: LEN_W];
      assign rd_len_arr[gi]  = bus.p_rd_len[gi*LEN_W +: LEN_W];
      assign wr_data_arr[gi] = bus.p_wr_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Arbitration: walk the ports starting one past the search origin, with
  // wrap. Fixed priority is the same walk with the origin pinned to the last
  // port, so port 0 is always looked at first.
  logic [N_PORTS-1:0] pend;
  logic               found;
  logic [IDX_W-1:0]   pick;
  logic               pick_wr;

  assign pend = bus.p_wr_req | bus.p_rd_req;

  always_comb begin : arb
    int               base;
    int               idx;
    logic [IDX_W-1:0] idx_v;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_v = '0;
    base  = (RR_EN != 0) ? int'(last_grant_q) : N_PORTS - 1;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx = base + k;
      if (idx >= N_PORTS) idx = idx - N_PORTS;
      idx_v = IDX_W'(idx);
      if (!found && pend[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
    end
  end

  // A port asserting both requests gets the WR_PRIO-preferred operation;
  // the other request simply stays pending for a later grant.
  assign pick_wr = bus.p_wr_req[pick] & ((WR_PRIO != 0) | ~bus.p_rd_req[pick]);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    wr_req_d     = wr_req_q;
    rd_req_d     = rd_req_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    wr_len_d     = wr_len_q;
    rd_len_d     = rd_len_q;
    done_d       = '0;
    err_d        = '0;
    case (state_q)
      IDLE: begin
        if (bus.init_end && found) begin
          grant_d      = pick;
          last_grant_d = pick;
          cnt_d        = '0;
          if (pick_wr) begin
            state_d   = WR_WAIT;
            wr_req_d  = 1'b1;
            wr_addr_d = wr_addr_arr[pick];
            wr_len_d  = wr_len_arr[pick];
          end else begin
            state_d   = RD_WAIT;
            rd_req_d  = 1'b1;
            rd_addr_d = rd_addr_arr[pick];
            rd_len_d  = rd_len_arr[pick];
          end
        end
      end
      WR_WAIT: begin
        if (bus.sdram_wr_ack) begin
          wr_req_d = 1'b0;
          state_d  = WR_BURST;
        end else if (cnt_q == CNT_LAST) begin
          // Controller never answered: abandon the burst.
          wr_req_d       = 1'b0;
          err_d[grant_q] = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_BURST: begin
        if (!bus.sdram_wr_ack) begin
          done_d[grant_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      RD_WAIT: begin
        if (bus.sdram_rd_ack) begin
          rd_req_d = 1'b0;
          state_d  = RD_BURST;
        end else if (cnt_q == CNT_LAST) begin
          rd_req_d       = 1'b0;
          err_d[grant_q] = 1'b1;
          state_d        = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_BURST: begin
        if (!bus.sdram_rd_ack) begin
          done_d[grant_q] = 1'b1;
          state_d         = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_PORT;
      cnt_q        <= '0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      wr_len_q     <= '0;
      rd_len_q     <= '0;
      done_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      wr_req_q     <= wr_req_d;
      rd_req_q     <= rd_req_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      wr_len_q     <= wr_len_d;
      rd_len_q     <= rd_len_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Strobes are only forwarded while a matching transaction owns the bus,
  // so a stray controller ack in IDLE (or of the other direction) is dropped.
  logic               busy_wr;
  logic               busy_rd;
  logic [N_PORTS-1:0] wr_ack_v;
  logic [N_PORTS-1:0] rd_ack_v;

  assign busy_wr = (state_q == WR_WAIT) || (state_q == WR_BURST);
  assign busy_rd = (state_q == RD_WAIT) || (state_q == RD_BURST);

  always_comb begin
    wr_ack_v = '0;
    rd_ack_v = '0;
    if (busy_wr) wr_ack_v[grant_q] = bus.sdram_wr_ack;
    if (busy_rd) rd_ack_v[grant_q] = bus.sdram_rd_ack;
  end

  assign bus.p_wr_ack      = wr_ack_v;
  assign bus.p_rd_ack      = rd_ack_v;
  assign bus.p_rd_data     = bus.sdram_rd_data;
  assign bus.p_done        = done_q;
  assign bus.p_err         = err_q;
  assign bus.sdram_wr_req  = wr_req_q;
  assign bus.sdram_rd_req  = rd_req_q;
  assign bus.sdram_wr_addr = wr_addr_q;
  assign bus.sdram_rd_addr = rd_addr_q;
  assign bus.sdram_wr_len  = wr_len_q;
  assign bus.sdram_rd_len  = rd_len_q;
  assign bus.sdram_wr_data = wr_data_arr[grant_q];
  assign bus.grant_id      = 3'(grant_q);
endmodule

// File: tb/tb_sdram_mport_arb.sv
// tb_sdram_mport_arb
//   Directed bench for sdram_mport_arb (4 ports, round-robin, write
//   priority, TIMEOUT=15). The bench plays both the port masters and the
//   SDRAM controller; expected values are written out by hand.
module tb_sdram_mport_arb;
  localparam int N_PORTS = 4;
  localparam int ADDR_W  = 24;
  localparam int DATA_W  = 16;
  localparam int LEN_W   = 10;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  sdram_mport_arb_if #(
    .N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)
  ) bus ();

  sdram_mport_arb #(
    .N_PORTS(N_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
    .RR_EN(1), .WR_PRIO(1), .TIMEOUT(15)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input int port);
    logic [3:0] m;
    m = '0;
    m[port] = 1'b1;
    return m;
  endfunction

  // Acts as the controller for a burst that has just been granted: waits
  // wait_cyc cycles, raises the ack for 'beats' cycles, then checks the
  // forwarded strobe count and the p_done pulse.
  task automatic run_burst(input bit is_wr, input int port, input int wait_cyc,
                           input int beats, input bit drop, input string tag);
    int acks;
    acks = 0;
    for (int w = 0; w < wait_cyc; w++) tick();
    if (is_wr) bus.sdram_wr_ack = 1'b1;
    else       bus.sdram_rd_ack = 1'b1;
    for (int b = 0; b < beats; b++) begin
      #1;
      if (is_wr ? bus.p_wr_ack[port] : bus.p_rd_ack[port]) acks++;
      if (b == 0 && drop) begin
        if (is_wr) bus.p_wr_req[port] = 1'b0;
        else       bus.p_rd_req[port] = 1'b0;
      end
      tick();
    end
    bus.sdram_wr_ack = 1'b0;
    bus.sdram_rd_ack = 1'b0;
    tick();
    check_eq({tag, "_acks"}, 32'(acks), 32'(beats));
    check_eq({tag, "_done"}, 32'(bus.p_done), 32'(onehot(port)));
    $display("[TB] burst %s %s port %0d beats %0d strobes %0d done %b",
             tag, is_wr ? "WR" : "RD", port, beats, acks, bus.p_done);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    sys_rst           = 1'b1;
    bus.init_end      = 1'b0;
    bus.p_wr_req      = '0;
    bus.p_rd_req      = '0;
    bus.p_wr_addr     = '0;
    bus.p_rd_addr     = '0;
    bus.p_wr_len      = '0;
    bus.p_rd_len      = '0;
    bus.p_wr_data     = '0;
    bus.sdram_wr_ack  = 1'b0;
    bus.sdram_rd_ack  = 1'b0;
    bus.sdram_rd_data = '0;

    // Reset state.
    tick();
    tick();
    check_eq("rst_wr_req", 32'(bus.sdram_wr_req), 32'd0);
    check_eq("rst_rd_req", 32'(bus.sdram_rd_req), 32'd0);
    check_eq("rst_grant",  32'(bus.grant_id), 32'd0);
    check_eq("rst_done",   32'(bus.p_done), 32'd0);
    check_eq("rst_err",    32'(bus.p_err), 32'd0);
    sys_rst = 1'b0;

    // No grant before init_end, then port 0 write.
    bus.p_wr_req                = 4'b0001;
    bus.p_wr_addr[0*ADDR_W +: ADDR_W] = 24'h123456;
    bus.p_wr_len[0*LEN_W +: LEN_W]    = 10'd8;
    tick(); tick(); tick();
    check_eq("init_hold_wr_req", 32'(bus.sdram_wr_req), 32'd0);
    bus.init_end = 1'b1;
    tick();
    check_eq("init_wr_req",  32'(bus.sdram_wr_req), 32'd1);
    check_eq("init_wr_addr", 32'(bus.sdram_wr_addr), 32'h123456);
    check_eq("init_wr_len",  32'(bus.sdram_wr_len), 32'd8);
    check_eq("init_grant",   32'(bus.grant_id), 32'd0);
    $display("[TB] grant port %0d WR addr %h len %0d", bus.grant_id, bus.sdram_wr_addr, bus.sdram_wr_len);
    run_burst(1'b1, 0, 2, 8, 1'b1, "p0wr");
    tick();
    check_eq("p0_done_pulse", 32'(bus.p_done), 32'd0);
    check_eq("p0_idle_wr_req", 32'(bus.sdram_wr_req), 32'd0);

    // Port 2 requests both: write first, then read.
    bus.p_wr_addr[2*ADDR_W +: ADDR_W] = 24'hA00020;
    bus.p_rd_addr[2*ADDR_W +: ADDR_W] = 24'hB00020;
    bus.p_wr_len[2*LEN_W +: LEN_W]    = 10'd8;
    bus.p_rd_len[2*LEN_W +: LEN_W]    = 10'd4;
    bus.p_wr_data[2*DATA_W +: DATA_W] = 16'hBEEF;
    bus.p_wr_req = 4'b0100;
    bus.p_rd_req = 4'b0100;
    tick();
    check_eq("both_grant",   32'(bus.grant_id), 32'd2);
    check_eq("both_wr_req",  32'(bus.sdram_wr_req), 32'd1);
    check_eq("both_rd_req",  32'(bus.sdram_rd_req), 32'd0);
    check_eq("both_wr_addr", 32'(bus.sdram_wr_addr), 32'hA00020);
    check_eq("both_wr_data", 32'(bus.sdram_wr_data), 32'hBEEF);
    $display("[TB] grant port %0d WR addr %h len %0d", bus.grant_id, bus.sdram_wr_addr, bus.sdram_wr_len);
    run_burst(1'b1, 2, 1, 8, 1'b1, "p2wr");
    check_eq("gap_rd_req", 32'(bus.sdram_rd_req), 32'd0);
    tick();
    check_eq("p2rd_req",    32'(bus.sdram_rd_req), 32'd1);
    check_eq("p2rd_grant",  32'(bus.grant_id), 32'd2);
    check_eq("p2rd_addr",   32'(bus.sdram_rd_addr), 32'hB00020);
    check_eq("p2rd_len",    32'(bus.sdram_rd_len), 32'd4);
    check_eq("p2wr_done_clr", 32'(bus.p_done), 32'd0);
    bus.sdram_rd_data = 16'h5A5A;
    #1;
    check_eq("rd_data_pass", 32'(bus.p_rd_data), 32'h5A5A);
    $display("[TB] grant port %0d RD addr %h len %0d", bus.grant_id, bus.sdram_rd_addr, bus.sdram_rd_len);
    run_burst(1'b0, 2, 0, 4, 1'b1, "p2rd");
    tick();

    // Timeout on port 1 write: controller never answers.
    bus.p_wr_req = 4'b0010;
    tick();
    check_eq("to_grant", 32'(bus.grant_id), 32'd1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (!bus.sdram_wr_req) break;
      cnt++;
      tick();
    end
    check_eq("to_req_cycles", 32'(cnt), 32'd15);
    check_eq("to_err",        32'(bus.p_err), 32'b0010);
    check_eq("to_done",       32'(bus.p_done), 32'd0);
    $display("[TB] timeout port 1 req cycles %0d err %b", cnt, bus.p_err);
    bus.p_wr_req = 4'b0000;
    tick();
    check_eq("to_err_pulse", 32'(bus.p_err), 32'd0);

    // Stray controller ack in IDLE is not forwarded.
    bus.sdram_wr_ack = 1'b1;
    #1;
    check_eq("idle_ack_fwd", 32'(bus.p_wr_ack), 32'd0);
    tick();
    check_eq("idle_ack_req",  32'(bus.sdram_wr_req), 32'd0);
    check_eq("idle_ack_done", 32'(bus.p_done), 32'd0);
    bus.sdram_wr_ack = 1'b0;
    tick();

    // Ports 1 and 2 read; last grant was 1 (the timed-out port), so 2 wins.
    bus.p_rd_req = 4'b0110;
    tick();
    check_eq("rr_after_to_grant", 32'(bus.grant_id), 32'd2);
    check_eq("rr_after_to_rd_req", 32'(bus.sdram_rd_req), 32'd1);
    tick();
    bus.sdram_rd_ack = 1'b1;
    tick();
    tick();
    check_eq("mid_burst_rd_ack", 32'(bus.p_rd_ack), 32'b0100);
    sys_rst = 1'b1;
    #1;
    check_eq("rst_mid_rd_ack", 32'(bus.p_rd_ack), 32'd0);
    check_eq("rst_mid_rd_req", 32'(bus.sdram_rd_req), 32'd0);
    check_eq("rst_mid_grant",  32'(bus.grant_id), 32'd0);
    check_eq("rst_mid_done",   32'(bus.p_done), 32'd0);
    tick();
    tick();
    check_eq("rst_hold_done", 32'(bus.p_done), 32'd0);
    check_eq("rst_hold_err",  32'(bus.p_err), 32'd0);
    $display("[TB] reset during RD burst, outputs cleared");
    bus.sdram_rd_ack = 1'b0;
    bus.p_rd_req     = 4'b1111;
    sys_rst          = 1'b0;

    // All four ports read continuously: round-robin order 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq($sformatf("rr%0d_grant", i), 32'(bus.grant_id), 32'(i % 4));
      check_eq($sformatf("rr%0d_rd_req", i), 32'(bus.sdram_rd_req), 32'd1);
      check_eq($sformatf("rr%0d_done_clr", i), 32'(bus.p_done), 32'd0);
      $display("[TB] grant port %0d RD (round-robin step %0d)", bus.grant_id, i);
      run_burst(1'b0, i % 4, 0, 4, 1'b0, $sformatf("rr%0d", i));
    end
    bus.p_rd_req = 4'b0000;
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
